// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy game pipeline (draw_game, game_ctrl).
package flappy_pkg;

  localparam int unsigned BIRD_X      = 200;
  localparam int unsigned BIRD_WIDTH  = 40;
  localparam int unsigned BIRD_HEIGHT = 30;
  localparam int unsigned TUBE_WIDTH  = 120;
  localparam int unsigned GAP_HEIGHT  = 150;
  localparam int unsigned N_TUBES     = 3;
  localparam int unsigned OVER_FRAMES = 60;

  localparam int unsigned TUBE_XW    = 11;
  localparam int unsigned OVER_CNT_W = $clog2(OVER_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;
  typedef logic [11:0] bcd3_t;

  // Adds a small increment to one BCD digit; returns {carry, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] d, input logic [1:0] inc);
    logic [4:0] s;
    s = 5'(d) + 5'(inc);
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Three-digit BCD add of a 0..3 increment, saturating at 999, plus a compare against b.
module bcd_add_sat
  import flappy_pkg::*;
(
  input  bcd3_t      a,
  input  logic [1:0] inc,
  input  bcd3_t      b,
  output bcd3_t      sum_c,
  output logic       gt_c
);

  logic [4:0] d0, d1, d2;

  always_comb begin
    d0 = bcd_digit_add(a[3:0], inc);
    d1 = bcd_digit_add(a[7:4], {1'b0, d0[4]});
    d2 = bcd_digit_add(a[11:8], {1'b0, d1[4]});
    if (d2[4]) sum_c = 12'h999;
    else       sum_c = {d2[3:0], d1[3:0], d0[3:0]};
  end

  // Valid BCD digits order identically to binary, so a plain compare is digit-wise MSB first.
  assign gt_c = (sum_c > b);

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/PLAY/OVER sequencing, tube-pass scoring and best score tracking.
module game_ctrl
  import flappy_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         mouse_left,
  input  logic                         collision,
  input  logic [N_TUBES*TUBE_XW-1:0]   tube_x,
  output logic                         game_rst,
  output logic                         mouse_left_game,
  output logic                         game_over,
  output logic [11:0]                  score,
  output logic [11:0]                  best
);

  localparam logic [OVER_CNT_W-1:0] OVER_CNT_MAX = OVER_CNT_W'(OVER_FRAMES);

  game_state_t               state;
  logic                      mouse_left_d;
  logic [N_TUBES-1:0]        behind_prev;
  logic [OVER_CNT_W-1:0]     over_cnt;

  logic [N_TUBES-1:0]        behind_c;
  logic [N_TUBES-1:0]        pass_c;
  logic [1:0]                pass_cnt_c;
  logic [1:0]                inc_c;
  logic                      click_c;
  bcd3_t                     score_sum_c;
  logic                      sum_gt_best_c;

  // A slot is behind the bird once its right edge clears BIRD_X; 12-bit sum avoids overflow.
  always_comb begin
    behind_c   = '0;
    pass_cnt_c = '0;
    for (int i = 0; i < N_TUBES; i++) begin
      logic [TUBE_XW-1:0] slot;
      slot        = tube_x[i*TUBE_XW +: TUBE_XW];
      behind_c[i] = ~slot[TUBE_XW-1] &
                    (({1'b0, slot} + 12'(TUBE_WIDTH)) < 12'(BIRD_X));
    end
    pass_c = behind_c & ~behind_prev;
    for (int i = 0; i < N_TUBES; i++) begin
      pass_cnt_c = pass_cnt_c + 2'(pass_c[i]);
    end
  end

  assign click_c = mouse_left & ~mouse_left_d;
  assign inc_c   = (frame_tick && state == PLAY) ? pass_cnt_c : 2'd0;

  bcd_add_sat u_bcd_add_sat (
    .a     (score),
    .inc   (inc_c),
    .b     (best),
    .sum_c (score_sum_c),
    .gt_c  (sum_gt_best_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      game_rst        <= 1'b1;
      mouse_left_game <= 1'b0;
      game_over       <= 1'b0;
      score           <= '0;
      best            <= '0;
      over_cnt        <= '0;
      mouse_left_d    <= 1'b0;
      behind_prev     <= '0;
    end else begin
      mouse_left_d    <= mouse_left;
      mouse_left_game <= mouse_left & (state == PLAY);
      if (frame_tick) behind_prev <= behind_c;

      case (state)
        IDLE: begin
          score <= '0;
          if (click_c) begin
            state    <= PLAY;
            game_rst <= 1'b0;
          end
        end
        PLAY: begin
          score <= score_sum_c;
          // Passes in the collision cycle still count and feed the best compare.
          if (collision) begin
            state     <= OVER;
            game_over <= 1'b1;
            over_cnt  <= '0;
            if (sum_gt_best_c) best <= score_sum_c;
          end
        end
        OVER: begin
          if (frame_tick && over_cnt != OVER_CNT_MAX) over_cnt <= over_cnt + OVER_CNT_W'(1);
          if (click_c && over_cnt == OVER_CNT_MAX) begin
            state     <= IDLE;
            game_rst  <= 1'b1;
            game_over <= 1'b0;
            score     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          game_rst  <= 1'b1;
          game_over <= 1'b0;
          score     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed game scenarios followed by randomized play.
module tb_game_ctrl;
  import flappy_pkg::*;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic mouse_left = 1'b0;
  logic collision = 1'b0;
  logic [N_TUBES*TUBE_XW-1:0] tube_x = '1;
  logic game_rst, mouse_left_game, game_over;
  logic [11:0] score, best;

  game_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .mouse_left      (mouse_left),
    .collision       (collision),
    .tube_x          (tube_x),
    .game_rst        (game_rst),
    .mouse_left_game (mouse_left_game),
    .game_over       (game_over),
    .score           (score),
    .best            (best)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        grst;
    logic        mlg;
    logic        gover;
    logic [11:0] score;
    logic [11:0] best;
  } exp_t;

  exp_t exp_q[$];
  exp_t rst_q[$];
  int checks = 0;
  int passed = 0;

  int tx[N_TUBES];

  // Behavioural model: plain integers for score/best, mode as a small int.
  int m_mode, m_score, m_best, m_over;
  bit m_ml_d, m_mlg;
  bit m_prev[N_TUBES];

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.grst  = (m_mode == M_IDLE);
    e.mlg   = m_mlg;
    e.gover = (m_mode == M_OVER);
    e.score = to_bcd(m_score);
    e.best  = to_bcd(m_best);
    return e;
  endfunction

  function automatic void m_reset();
    m_mode = M_IDLE; m_score = 0; m_best = 0; m_over = 0;
    m_ml_d = 1'b0; m_mlg = 1'b0;
    for (int i = 0; i < N_TUBES; i++) m_prev[i] = 1'b0;
  endfunction

  function automatic void model_step(input bit ml, input bit coll, input bit ft);
    bit click;
    int passes;
    int nm;
    bit beh[N_TUBES];
    click  = ml && !m_ml_d;
    passes = 0;
    for (int i = 0; i < N_TUBES; i++) begin
      beh[i] = (tx[i] < 1024) && (tx[i] + int'(TUBE_WIDTH) < int'(BIRD_X));
      if (beh[i] && !m_prev[i]) passes++;
    end
    m_mlg = ml && (m_mode == M_PLAY);
    nm = m_mode;
    if (m_mode == M_IDLE) begin
      m_score = 0;
      if (click) nm = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (ft) m_score = (m_score + passes > 999) ? 999 : m_score + passes;
      if (coll) begin
        nm = M_OVER;
        m_over = 0;
        if (m_score > m_best) m_best = m_score;
      end
    end else begin
      if (click && m_over == int'(OVER_FRAMES)) begin
        nm = M_IDLE;
        m_score = 0;
      end else if (ft && m_over < int'(OVER_FRAMES)) begin
        m_over++;
      end
    end
    if (ft) for (int i = 0; i < N_TUBES; i++) m_prev[i] = beh[i];
    m_ml_d = ml;
    m_mode = nm;
  endfunction

  task automatic check(input string name, input exp_t e);
    checks++;
    if (game_rst === e.grst && mouse_left_game === e.mlg && game_over === e.gover &&
        score === e.score && best === e.best) begin
      passed++;
    end else begin
      $display("FAIL %s t=%0t got rst=%b mlg=%b over=%b score=%h best=%h expected rst=%b mlg=%b over=%b score=%h best=%h",
               name, $time, game_rst, mouse_left_game, game_over, score, best,
               e.grst, e.mlg, e.gover, e.score, e.best);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check("cycle", exp_q.pop_front());
    end
  end

  // Asynchronous reset must take effect before any clock edge.
  initial begin
    forever begin
      @(posedge rst);
      #1;
      if (rst_q.size() != 0) check("async_rst", rst_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  task automatic cyc(input bit ml, input bit coll, input bit ft);
    @(negedge clk);
    rst = 1'b0;
    mouse_left = ml;
    collision = coll;
    frame_tick = ft;
    for (int i = 0; i < N_TUBES; i++) tube_x[i*TUBE_XW +: TUBE_XW] = 11'(tx[i]);
    model_step(ml, coll, ft);
    exp_q.push_back(model_exp());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mouse_left = 1'b0;
    collision = 1'b0;
    frame_tick = 1'b0;
    m_reset();
    rst_q.push_back(model_exp());
    exp_q.push_back(model_exp());
  endtask

  task automatic click();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_tubes();
    for (int i = 0; i < N_TUBES; i++) tx[i] = 1100;
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic pump_one();
    tx[0] = 50;
    cyc(1'b0, 1'b0, 1'b1);
    tx[0] = 1100;
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic pump_to(input int target);
    while (m_score < target) pump_one();
  endtask

  task automatic leave_over();
    frames(int'(OVER_FRAMES));
    click();
  endtask

  initial begin
    int walk[4];
    walk = '{90, 85, 80, 75};
    for (int i = 0; i < N_TUBES; i++) tx[i] = 1100;
    m_reset();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0);

    // Passes in IDLE do not score.
    tx[0] = 50; cyc(1'b0, 1'b0, 1'b1);
    clear_tubes();

    // Game 1: start, held button forwarded only in PLAY, tube walk, double pass.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tx[0] = walk[k];
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
    tx[1] = 70; tx[2] = 60;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    clear_tubes();
    frames(9);
    click();
    cyc(1'b0, 1'b1, 1'b0);
    frames(50);
    click();

    // Game 2: score 7 over best 3 with a one-cycle collision.
    click();
    pump_to(7);
    cyc(1'b0, 1'b1, 1'b0);
    leave_over();

    // Game 3: pass and collision in the same frame.
    click();
    pump_to(7);
    tx[0] = 50;
    cyc(1'b0, 1'b1, 1'b1);
    tx[0] = 1100;
    leave_over();

    // Game 4: BCD carries and saturation, then click+collision together.
    click();
    pump_to(998);
    tx[0] = 50; tx[1] = 50;
    cyc(1'b0, 1'b0, 1'b1);
    clear_tubes();
    tx[0] = 50; tx[1] = 50; tx[2] = 50;
    cyc(1'b0, 1'b0, 1'b1);
    clear_tubes();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    leave_over();

    // Game 5: reset in the middle of play.
    click();
    pump_to(12);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0);

    // Randomized play.
    for (int i = 0; i < N_TUBES; i++) tx[i] = 300 + 150 * i;
    for (int c = 0; c < 8000; c++) begin
      bit ft, ml, coll;
      ft = (c % 4 == 0);
      if (ft) begin
        for (int i = 0; i < N_TUBES; i++) begin
          if (tx[i] >= 1024) begin
            if ($urandom_range(0, 3) == 0) tx[i] = 300 + int'($urandom_range(0, 400));
          end else begin
            tx[i] = tx[i] - int'($urandom_range(2, 8));
            if (tx[i] < 0) tx[i] = 1024 + int'($urandom_range(0, 1000));
          end
        end
      end
      ml = ($urandom_range(0, 7) == 0) ? ~m_ml_d : m_ml_d;
      coll = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3999) == 0) do_reset();
      cyc(ml, coll, ft);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0 && rst_q.size() == 0) passed++;
    else $display("FAIL drain got %0d/%0d pending entries expected 0/0", exp_q.size(), rst_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game-flow controller downstream of draw_game.
- Consumes the per-pixel collision flag and the tube positions; produces the game_rst and gated mouse_left that draw_game and its children consume.
- Runs the IDLE/PLAY/OVER state machine and keeps a 3-digit BCD score and best score for the HUD overlay.

Parameters:
- BIRD_X, 200, left edge of bird in pixels (must match draw_game)
- TUBE_WIDTH, 120, tube width in pixels (must match draw_game)
- N_TUBES, 3, number of tube slots
- OVER_FRAMES, 60, frames in OVER before a click is accepted

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank
- mouse_left  in  1  raw left button level, already synchronous to clk
- collision  in  1  per-pixel collision from draw_game
- tube_x  in  N_TUBES x 11  tube left-edge positions; a value of 1024 or more marks an inactive slot
- game_rst  out  1  holds game objects in initial position
- mouse_left_game  out  1  button forwarded to the game
- game_over  out  1  high while in OVER
- score  out  12  3-digit BCD, digits [11:8] [7:4] [3:0]
- best  out  12  best score, BCD

Behaviour:
- Reset (asynchronous, active-high), all registers:
  - state=IDLE; game_rst=1; mouse_left_game=0; game_over=0
  - score=0; best=0; over_cnt=0
  - click edge register=0; behind_prev=0 for every slot
- Click detection: click = mouse_left & ~mouse_left_d, where mouse_left_d is registered every cycle.
- Outputs are Moore and registered:
  - game_rst = (state==IDLE)
  - game_over = (state==OVER)
  - mouse_left_game = mouse_left & (state==PLAY); registered, so 1 cycle latency
- IDLE:
  - score held at 0.
  - click -> PLAY on the next edge. game_rst drops in the same cycle the state becomes PLAY.
- PLAY:
  - collision=1 in any cycle -> OVER on the next edge.
  - Collision is sampled every cycle. It is not latched to the frame; a single-pixel pulse is sufficient.
- OVER:
  - On entry: over_cnt=0; best <- score if score > best (BCD compare, digit-wise, most significant first).
  - over_cnt increments on frame_tick and saturates at OVER_FRAMES.
  - click with over_cnt==OVER_FRAMES -> IDLE. A click before that is ignored.
  - collision is ignored in OVER.
- Tube pass detection, evaluated only on frame_tick:
  - For each slot i: behind_i = (tube_x[i] < 1024) & (tube_x[i] + TUBE_WIDTH < BIRD_X). Use 12-bit addition so there is no overflow.
  - pass_i = behind_i & ~behind_prev[i].
  - behind_prev[i] <- behind_i on every frame_tick in all states.
  - In IDLE, behind_prev is updated but no score change occurs. Tubes reset to the right, so behind_prev clears naturally.
- Score update:
  - On frame_tick while state==PLAY, score += popcount(pass), range 0..N_TUBES.
  - Addition is BCD with per-digit carry and saturates at 999.
- Simultaneous events:
  - frame_tick with passes in the same cycle as collision in PLAY: the passes are counted, then the state moves to OVER. The best compare on OVER entry uses the updated score.
  - click and collision in the same PLAY cycle: collision wins.
- Reset mid-game: immediately returns to the IDLE outputs. best is cleared. No other clear path exists for best.
- Wrap-around: a tube slot leaving at x>=1024 and re-entering on the right yields behind=0, which re-arms pass detection.

Decomposition:
- flappy_pkg holds:
  - BIRD_X, BIRD_WIDTH, BIRD_HEIGHT, TUBE_WIDTH, GAP_HEIGHT, N_TUBES
  - typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t
  - typedef logic [11:0] bcd3_t
- draw_game imports the same constants from flappy_pkg.
- Sub-module bcd_add_sat:
  - combinational; inputs bcd3_t a and a 2-bit increment; output is the saturated bcd3_t.
  - also provides a greater-than output for the best compare.

Test Plan:
- Reset mid-PLAY with score=0x012 -> same cycle: game_rst=1, score=0x000, best=0x000, state IDLE.
- IDLE, one mouse_left rising edge -> game_rst=0 next cycle. mouse_left_game follows mouse_left 1 cycle later, and only in PLAY.
- PLAY with tube_x[0] stepping 90,85,80,75 over frame_ticks -> score increments once, at the frame where 75+120<200. Two tubes crossing in the same frame -> +2.
- score=0x998, two passes in one frame -> score=0x999, no wrap. score=0x099 plus one pass -> 0x100.
- Single-cycle collision pulse in PLAY with score=0x007 and best=0x003 -> game_over=1 next cycle, best=0x007.
- In OVER:
  - click at frame 10 -> stays OVER
  - after 60 frame_ticks, click -> IDLE with game_rst=1 and score=0; best retained.
